// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-style up/down sweep scheduler for an elevator car.
// Inputs : clk, reset (sync, active-low), call_mask (pending call per floor).
// Outputs: cur_floor, dir_up, moving, door_open, idle (all registered state),
//          clr_valid/clr_floor (one-cycle clear request to the call register file).
module elevator_scheduler #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_BITS    = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_mask,
  output logic [FLOOR_BITS-1:0] cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  idle,
  output logic                  clr_valid,
  output logic [FLOOR_BITS-1:0] clr_floor
);
  localparam int MAXC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t                state_q, state_d;
  logic [FLOOR_BITS-1:0] floor_q, floor_d, clr_floor_q, clr_floor_d, nxt;
  logic                  dir_q, dir_d, clr_q, clr_d;
  logic                  above, below, here, ahead_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;
  function automatic logic beyond(input logic [NUM_FLOORS-1:0] m,
                                  input logic [FLOOR_BITS-1:0] f, input logic up);
    beyond = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      beyond = beyond | (m[i] & (up ? (i > int'(f)) : (i < int'(f))));
  endfunction
  always_comb begin
    above       = beyond(call_mask, floor_q, 1'b1);
    below       = beyond(call_mask, floor_q, 1'b0);
    here        = call_mask[floor_q];
    nxt         = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
    ahead_nxt   = beyond(call_mask, nxt, dir_q);
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    clr_d       = 1'b0;
    clr_floor_d = clr_floor_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (here) begin
          state_d     = DOOR;
          clr_d       = 1'b1;
          clr_floor_d = floor_q;
        end else if (above || below) begin
          state_d = MOVE;
          // with calls on both sides keep the current sweep direction
          dir_d   = (above && below) ? dir_q : above;
        end
      end
      MOVE: begin
        if (cnt_q == CW'(TRAVEL_CYCLES - 1)) begin
          floor_d     = nxt;
          cnt_d       = '0;
          clr_d       = call_mask[nxt];
          clr_floor_d = nxt;
          state_d     = call_mask[nxt] ? DOOR : ahead_nxt ? MOVE : IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      DOOR: begin
        // while our own clear is in flight the bit is still set; ignore it then
        if (!clr_q && here) begin
          cnt_d       = '0;
          clr_d       = 1'b1;
          clr_floor_d = floor_q;
        end else if (cnt_q == CW'(DOOR_CYCLES - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      cnt_q       <= '0;
      clr_q       <= 1'b0;
      clr_floor_q <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      clr_floor_q <= clr_floor_d;
    end
  end
  assign cur_floor = floor_q;
  assign dir_up    = dir_q;
  assign moving    = state_q == MOVE;
  assign door_open = state_q == DOOR;
  assign idle      = state_q == IDLE;
  assign clr_valid = clr_q;
  assign clr_floor = clr_floor_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: timeline scoreboard for elevator_scheduler with a call register file model.
module tb_elevator_scheduler;
  logic       clk = 1'b0, reset = 1'b0, wipe = 1'b1;
  logic [7:0] calls = 8'h00, set_v = 8'hFF;
  logic [2:0] cur_floor, clr_floor;
  logic       dir_up, moving, door_open, idle, clr_valid;
  int         cyc = 0, n_chk = 0, n_fail = 0, t = 0;
  typedef struct {int at; string tag; logic [10:0] val;} exp_t;
  typedef struct {int off; logic [10:0] val;} vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  elevator_scheduler dut (
    .clk(clk), .reset(reset), .call_mask(calls), .cur_floor(cur_floor), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .idle(idle), .clr_valid(clr_valid), .clr_floor(clr_floor)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    calls <= wipe ? set_v : ((calls | set_v) & ~(clr_valid ? (8'h01 << clr_floor) : 8'h00));
  end
  wire [10:0] act = {cur_floor, dir_up, moving, door_open, idle, clr_valid, clr_floor};
  function automatic logic [10:0] care(logic [10:0] v);
    return {8'hFF, {3{v[3]}}};
  endfunction
  function automatic logic [10:0] idl(int fl, bit du);
    return {3'(fl), du, 4'b0010, 3'b000};
  endfunction
  function automatic logic [10:0] mov(int fl, bit du);
    return {3'(fl), du, 4'b1000, 3'b000};
  endfunction
  function automatic logic [10:0] dor(int fl, bit du, bit cv);
    return {3'(fl), du, 3'b010, cv, 3'(fl)};
  endfunction
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        n_chk++;
        if (sb[i].at < cyc || ((act & care(sb[i].val)) !== (sb[i].val & care(sb[i].val)))) begin
          n_fail++;
          $display("FAIL %s cyc %0d (due %0d): got {fl,dir,mv,door,idle,clr,cf}=%b want %b",
                   sb[i].tag, cyc, sb[i].at, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end
  task automatic wait_cyc(int c);
    do @(negedge clk); while (cyc < c);
  endtask
  task automatic pulse(logic [7:0] m);
    set_v = m;
    @(posedge clk);
    #1 set_v = 8'h00;
    t = cyc;
  endtask
  task automatic play(string tag);
    foreach (tbl[k]) sb.push_back('{t + tbl[k].off, tag, tbl[k].val});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    for (int c = 1; c <= 3; c++) sb.push_back('{c, "reset_hold", idl(0, 1)});
    wait_cyc(3);
    set_v = 8'h00;
    wait_cyc(4);
    reset = 1'b1;
    wipe  = 1'b0;
    sb.push_back('{5, "post_reset", idl(0, 1)});
    wait_cyc(6);
    pulse(8'h01);
    tbl = '{'{0, idl(0, 1)}, '{1, dor(0, 1, 1)}, '{2, dor(0, 1, 0)}, '{5, dor(0, 1, 0)},
            '{8, dor(0, 1, 0)}, '{9, idl(0, 1)}};
    play("same_floor");
    wait_cyc(t + 10);
    pulse(8'h08);
    tbl = '{'{0, idl(0, 1)}, '{1, mov(0, 1)}, '{4, mov(0, 1)}, '{5, mov(1, 1)}, '{8, mov(1, 1)},
            '{9, mov(2, 1)}, '{12, mov(2, 1)}, '{13, dor(3, 1, 1)}, '{14, dor(3, 1, 0)},
            '{17, dor(3, 1, 0)}, '{20, dor(3, 1, 0)}, '{21, idl(3, 1)}};
    play("single_call");
    wait_cyc(t + 22);
    pulse(8'h10);
    tbl = '{'{1, mov(3, 1)}, '{5, dor(4, 1, 1)}, '{13, idl(4, 1)}};
    play("to_floor4");
    wait_cyc(t + 14);
    pulse(8'h44);
    tbl = '{'{0, idl(4, 1)}, '{1, mov(4, 1)}, '{5, mov(5, 1)}, '{9, dor(6, 1, 1)}, '{17, idl(6, 1)},
            '{18, mov(6, 0)}, '{22, mov(5, 0)}, '{30, mov(3, 0)}, '{34, dor(2, 0, 1)},
            '{42, idl(2, 0)}};
    play("tie_pref");
    wait_cyc(t + 43);
    pulse(8'h01);
    tbl = '{'{1, mov(2, 0)}, '{9, dor(0, 0, 1)}, '{17, idl(0, 0)}};
    play("to_floor0");
    wait_cyc(t + 18);
    pulse(8'h80);
    tbl = '{'{1, mov(0, 1)}, '{9, mov(2, 1)}, '{13, mov(3, 1)}, '{17, mov(4, 1)},
            '{21, dor(5, 1, 1)}, '{29, idl(5, 1)}, '{30, mov(5, 1)}, '{38, dor(7, 1, 1)},
            '{46, idl(7, 1)}};
    play("en_route");
    wait_cyc(t + 9);
    pulse(8'h20);
    wait_cyc(t + 37);
    pulse(8'h08);
    tbl = '{'{1, mov(7, 0)}, '{13, mov(4, 0)}, '{17, dor(3, 0, 1)}, '{20, dor(3, 0, 0)},
            '{21, dor(3, 0, 1)}, '{22, dor(3, 0, 0)}, '{25, dor(3, 0, 0)}, '{28, dor(3, 0, 0)},
            '{29, idl(3, 0)}};
    play("door_hold");
    wait_cyc(t + 19);
    pulse(8'h08);
    wait_cyc(t + 11);
    pulse(8'h80);
    tbl = '{'{1, mov(3, 1)}, '{6, mov(4, 1)}, '{7, idl(0, 1)}, '{8, idl(0, 1)}};
    play("reset_move");
    wait_cyc(t + 6);
    reset = 1'b0;
    wipe  = 1'b1;
    wait_cyc(t + 7);
    reset = 1'b1;
    wipe  = 1'b0;
    wait_cyc(t + 9);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    if (n_chk < 40) begin
      n_fail++;
      $display("FAIL coverage: only %0d expectations evaluated", n_chk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
